lsu_bus_bridge: RTL and testbench
=================================

LSU_BUS_BRIDGE -- requirements
Module: lsu_bus_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of cycles after request launch without bus_rsp_valid before the access aborts with bus_err.
REQ-002 Ports, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  core load request, level, held while stall=1.
- wr_en  input  1  core store request, level, held while stall=1.
- addr  input  32  byte address from the ALU result.
- mem_acc_mode  input  3  access mode: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- wdata  input  32  store data, from rs2.
- rdata  output  32  extended load data to the writeback mux.
- stall  output  1  holds the PC and register-file write while high.
- misalign_err  output  1  one-cycle pulse for an unaligned access.
- bus_err  output  1  one-cycle pulse when an access times out.
- bus_req_valid  output  1  bus request valid.
- bus_req_ready  input  1  bus accepts the request.
- bus_addr  output  32  word-aligned address, addr[1:0] forced to 00.
- bus_we  output  1  1 = write.
- bus_wstrb  output  4  byte-lane write strobes.
- bus_wdata  output  32  lane-replicated store data.
- bus_rsp_valid  input  1  read data / write acknowledge valid.
- bus_rdata  input  32  raw word read data.

Function
REQ-003 FSM states: IDLE, REQ, WAIT, DONE.
REQ-004 IDLE: when rd_en or wr_en is high and the access is aligned, latch addr, mode, wdata and direction, then go to REQ.
REQ-005 Direction priority: wr_en=rd_en=1 is a store.
REQ-006 Alignment rules: H/HU need addr[0]=0; W needs addr[1:0]=00; B/BU are always aligned.
REQ-007 Misaligned access:
- stays in IDLE; no bus request is issued;
- misalign_err=1 and stall=0 in the same cycle; rdata=0;
- the store is suppressed.
REQ-008 Illegal mode codes (011, 110, 111) behave exactly as misaligned.
REQ-009 stall is combinational: 1 when (rd_en|wr_en) is high, the access is aligned, and state is not DONE; 0 in DONE.
REQ-010 REQ: bus_req_valid=1 with stable bus_addr, bus_we, bus_wstrb and bus_wdata until bus_req_ready=1, then go to WAIT.
REQ-011 WAIT: on bus_rsp_valid=1, capture bus_rdata and go to DONE.
REQ-012 bus_rsp_valid is ignored in IDLE, REQ and DONE.
REQ-013 DONE lasts exactly one cycle:
- stall=0 and rdata is valid, so the core commits;
- next state is IDLE.
REQ-014 Minimum latency: 3 stall cycles (ready and response each the cycle after they are waited for).
REQ-015 Back-to-back: a new access presented in the cycle after DONE is accepted from IDLE normally.
REQ-016 Timeout counter:
- cleared on entry to REQ; increments each cycle in REQ or WAIT;
- at TIMEOUT_CYCLES, go to DONE with bus_err=1 and rdata=0, and drop bus_req_valid;
- a response arriving late is ignored under REQ-012.
REQ-017 Store strobes: SB gives 0001<<addr[1:0]; SH gives 0011<<addr[1:0]; SW gives 1111. bus_wdata replicates the byte or halfword across all lanes.
REQ-018 Loads: select the lane by addr[1:0]. B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.
REQ-019 rdata is 0 in every cycle except DONE of a load.

Reset
REQ-020 While rst=1, the next state is IDLE and the counter and latched fields clear.
REQ-021 Output values under reset: stall=0, bus_req_valid=0, bus_we=0, bus_wstrb=0, rdata=0, misalign_err=0, bus_err=0.
REQ-022 Reset mid-access abandons the transaction. No bus request is reissued; stale responses are ignored until a new request is accepted.

Structure
REQ-023 Shared package lsu_pkg holds:
- the mem_acc_mode enum (shared with the controller);
- the FSM state enum;
- the default TIMEOUT_CYCLES.
REQ-024 Combinational sub-module lsu_align holds the strobe/lane-replication and load extract/extend logic; lsu_bus_bridge holds the FSM and counter.

Verification
REQ-025 LB at addr 0x103, bus_rdata 0x80FF_FF12, ready and response each after 1 cycle -> bus_addr 0x100, 3 stall cycles, rdata 0xFFFF_FF80 in DONE.
REQ-026 SH wdata 0x0000_BEEF at addr 0x202 -> bus_addr 0x200, bus_we=1, bus_wstrb 1100, bus_wdata 0xBEEF_BEEF, stall drops after the acknowledge.
REQ-027 LW at addr 0x006 -> misalign_err pulse, stall=0, bus_req_valid never asserted.
REQ-028 TIMEOUT_CYCLES=4, bus_req_ready held 0 -> bus_err pulse after 4 cycles, rdata=0, then a stray bus_rsp_valid in IDLE is ignored.
REQ-029 rst asserted in WAIT, then LHU at addr 0x10 with bus_rdata 0x1234_8001 -> no reissue of the old request, rdata 0x0000_8001.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: access modes, bridge FSM states and defaults shared by the LSU and the core controller
package lsu_pkg;
  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } mem_acc_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_e;
  localparam int unsigned LSU_TIMEOUT_CYCLES = 255;
  // Illegal mode codes report as unaligned so they share the misalign path
  function automatic logic acc_aligned(input logic [2:0] mode, input logic [1:0] off);
    return mode == MODE_W ? off == 2'b00 :
           (mode == MODE_H || mode == MODE_HU) ? !off[0] :
           (mode == MODE_B || mode == MODE_BU);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store strobe/lane replication and load lane extract with sign/zero extension
module lsu_align import lsu_pkg::*; (
  input  mem_acc_mode_e mode,
  input  logic [1:0]    off,
  input  logic [31:0]   wdata,
  input  logic [31:0]   word,
  output logic [3:0]    wstrb,
  output logic [31:0]   wdata_rep,
  output logic [31:0]   rdata_ext
);
  logic [31:0] sh;
  logic byte_acc, half_acc, sext;
  always_comb begin
    byte_acc  = mode[1:0] == 2'b00;
    half_acc  = mode[1:0] == 2'b01;
    sext      = !mode[2];
    sh        = word >> {off, 3'b000};
    wstrb     = byte_acc ? 4'b0001 << off : half_acc ? 4'b0011 << off : 4'b1111;
    wdata_rep = byte_acc ? {4{wdata[7:0]}} : half_acc ? {2{wdata[15:0]}} : wdata;
    rdata_ext = byte_acc ? {{24{sext & sh[7]}}, sh[7:0]} :
                half_acc ? {{16{sext & sh[15]}}, sh[15:0]} : word;
  end
endmodule

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: stalls the core while a load/store runs as a single valid/ready bus transaction
module lsu_bus_bridge import lsu_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  lsu_state_e    state, state_nx;
  mem_acc_mode_e mode_q;
  logic [31:0]   addr_q, wdata_q, rsp_q, rdata_ext;
  logic [3:0]    strb;
  logic [CW-1:0] cnt;
  logic          we_q, err_q, req, ok, tmo;
  assign req = rd_en | wr_en;
  assign ok  = acc_aligned(mem_acc_mode, addr[1:0]);
  assign tmo = cnt >= CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = req && ok ? ST_REQ : ST_IDLE;
      ST_REQ:  state_nx = bus_req_ready ? ST_WAIT : tmo ? ST_DONE : ST_REQ;
      ST_WAIT: state_nx = bus_rsp_valid || tmo ? ST_DONE : ST_WAIT;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= MODE_B;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ST_REQ || state == ST_WAIT) ? cnt + 1'b1 : '0;
      // Store wins when both enables are high
      if (state == ST_IDLE && req && ok) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        mode_q  <= mem_acc_mode_e'(mem_acc_mode);
        we_q    <= wr_en;
      end
      if (state == ST_WAIT && bus_rsp_valid) rsp_q <= bus_rdata;
      err_q <= state_nx == ST_DONE && !(state == ST_WAIT && bus_rsp_valid);
    end
  end
  lsu_align u_align (
    .mode      (mode_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .word      (rsp_q),
    .wstrb     (strb),
    .wdata_rep (bus_wdata),
    .rdata_ext (rdata_ext)
  );
  assign stall         = !rst && req && ok && state != ST_DONE;
  assign misalign_err  = !rst && state == ST_IDLE && req && !ok;
  assign bus_req_valid = !rst && state == ST_REQ;
  assign bus_err       = !rst && state == ST_DONE && err_q;
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_we        = bus_req_valid && we_q;
  assign bus_wstrb     = bus_req_valid ? strb : 4'b0000;
  assign rdata         = !rst && state == ST_DONE && !we_q && !err_q ? rdata_ext : 32'h0;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed accesses checked every cycle against a transaction-level bridge model
module tb_lsu_bus_bridge;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en, bus_req_ready, bus_rsp_valid;
  logic [31:0] addr, wdata, bus_rdata;
  logic [2:0]  mem_acc_mode;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misalign_err, bus_err, bus_req_valid, bus_we;
  logic [3:0]  bus_wstrb;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .mem_acc_mode(mem_acc_mode), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign_err(misalign_err), .bus_err(bus_err), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_on = 0;
  logic        e_stall, e_mis, e_err, e_valid, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_strb;
  int          nstall, nvalid;
  logic        obs_mis, obs_err, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_size(input logic [2:0] m);
    return (m == 3'd0 || m == 3'd4) ? 1 : (m == 3'd1 || m == 3'd5) ? 2 : 4;
  endfunction

  function automatic bit m_aligned(input logic [2:0] m, input logic [31:0] a);
    if (m == 3'd3 || m > 3'd5) return 0;
    return (int'(a[1:0]) % m_size(m)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] m, input logic [31:0] a);
    logic [3:0] s = '0;
    int o = int'(a[1:0]);
    for (int i = 0; i < 4; i++) if (i >= o && i < o + m_size(m)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_size(m)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a, input logic [31:0] w);
    int n = m_size(m);
    longint v = (longint'(w) >> (8 * int'(a[1:0]))) & ((64'd1 << (8 * n)) - 1);
    if (m < 3'd4 && n < 4 && v >= longint'(64'd1 << (8 * n - 1))) v = v - longint'(64'd1 << (8 * n));
    return v[31:0];
  endfunction

  always @(negedge clk) if (chk_on) begin
    check("stall", stall, e_stall);
    check("misalign_err", misalign_err, e_mis);
    check("bus_err", bus_err, e_err);
    check("bus_req_valid", bus_req_valid, e_valid);
    check("rdata", rdata, e_rdata);
    if (e_valid) begin
      check("bus_addr", bus_addr, e_addr);
      check("bus_we", bus_we, e_we);
      if (e_we) begin
        check("bus_wstrb", bus_wstrb, e_strb);
        check("bus_wdata", bus_wdata, e_wdata);
      end
    end else if (rst) begin
      check("bus_we_rst", bus_we, 0);
      check("bus_wstrb_rst", bus_wstrb, 0);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (stall) nstall++;
    if (bus_req_valid) begin
      nvalid++;
      obs_addr = bus_addr; obs_we = bus_we; obs_strb = bus_wstrb; obs_wdata = bus_wdata;
    end
    obs_mis = obs_mis | misalign_err;
    obs_err = obs_err | bus_err;
    obs_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    nstall = 0; nvalid = 0; obs_mis = 0; obs_err = 0; obs_we = 0;
    obs_addr = '0; obs_wdata = '0; obs_strb = '0; obs_rdata = '0;
  endtask

  task automatic set_exp(input logic st, input logic mis, input logic er, input logic v, input logic [31:0] rd);
    e_stall = st; e_mis = mis; e_err = er; e_valid = v; e_rdata = rd;
  endtask

  task automatic idle(input logic rv, input logic [31:0] junk);
    rd_en = 0; wr_en = 0; bus_req_ready = 0; bus_rsp_valid = rv; bus_rdata = junk;
    set_exp(0, 0, 0, 0, 0);
    tick();
    bus_rsp_valid = 0;
  endtask

  // r / s: cycles waited in REQ / WAIT before ready / response (large = never)
  task automatic access(input bit rd, input bit wr, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input int r, input int s, input logic [31:0] w);
    int i = 0, j = 0, n = 0;
    bit in_wait = 0, done = 0, err = 0;
    clear_obs();
    rd_en = rd; wr_en = wr; mem_acc_mode = m; addr = a; wdata = wd; bus_rdata = w;
    bus_req_ready = 0; bus_rsp_valid = 0;
    if (!m_aligned(m, a)) begin
      set_exp(0, 1, 0, 0, 0);
      tick();
      return;
    end
    e_addr = a & ~32'h3; e_we = wr; e_strb = m_strb(m, a); e_wdata = m_wdata(m, wd);
    set_exp(1, 0, 0, 0, 0);
    tick();
    while (!done) begin
      bus_req_ready = !in_wait && i == r;
      bus_rsp_valid = in_wait && j == s;
      set_exp(1, 0, 0, !in_wait, 0);
      tick();
      if (!in_wait) begin
        if (i == r) in_wait = 1;
        else if (n >= T - 1) begin done = 1; err = 1; end
        i++;
      end else begin
        if (j == s) done = 1;
        else if (n >= T - 1) begin done = 1; err = 1; end
        j++;
      end
      n++;
    end
    bus_req_ready = 0; bus_rsp_valid = 0;
    set_exp(0, 0, err, 0, (err || wr) ? 32'h0 : m_load(m, a, w));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1; rd_en = 1; wr_en = 0; addr = 0; mem_acc_mode = 3'b010; wdata = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
    clear_obs();
    set_exp(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_on = 1;
    tick();
    tick();
    rst = 0;
    idle(0, 0);

    access(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF_FF12);
    check("lb_addr", obs_addr, 32'h100);
    check("lb_stalls", nstall, 3);
    check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    idle(0, 0);

    access(0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 1, 1, 0);
    check("sh_addr", obs_addr, 32'h200);
    check("sh_we", obs_we, 1);
    check("sh_strb", obs_strb, 4'b1100);
    check("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    check("sh_stalls", nstall, 5);
    idle(0, 0);

    access(1, 0, 3'b010, 32'h006, 0, 0, 0, 32'h1111_1111);
    check("lw_mis_pulse", obs_mis, 1);
    check("lw_mis_novalid", nvalid, 0);
    idle(0, 0);

    access(1, 0, 3'b001, 32'h002, 0, 0, 1, 32'h8001_7FFF);
    check("lh_rdata", obs_rdata, 32'hFFFF_8001);
    idle(0, 0);
    access(1, 0, 3'b100, 32'h001, 0, 1, 0, 32'h0000_AB00);
    access(1, 1, 3'b000, 32'h101, 32'h0000_005A, 0, 2, 32'hFFFF_FFFF);
    check("sb_prio_we", obs_we, 1);
    check("sb_prio_rdata", obs_rdata, 0);
    access(0, 1, 3'b010, 32'h044, 32'h1234_5678, 2, 0, 0);
    access(1, 0, 3'b011, 32'h000, 0, 0, 0, 0);
    access(1, 0, 3'b101, 32'h003, 0, 0, 0, 0);
    access(0, 1, 3'b111, 32'h004, 32'hFFFF_FFFF, 0, 0, 0);
    check("illegal_novalid", nvalid, 0);
    idle(0, 0);

    access(1, 0, 3'b010, 32'h008, 0, 0, 0, 32'hDEAD_BEEF);
    access(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h7F00_0000);
    check("b2b_rdata", obs_rdata, 32'h0000_007F);
    idle(0, 0);

    access(1, 0, 3'b010, 32'h020, 0, 99, 0, 32'hAAAA_AAAA);
    check("tmo_err", obs_err, 1);
    check("tmo_rdata", obs_rdata, 0);
    check("tmo_stalls", nstall, 5);
    idle(1, 32'h5555_5555);
    idle(0, 0);
    access(1, 0, 3'b010, 32'h030, 0, 0, 99, 32'hAAAA_AAAA);
    check("tmo_wait_err", obs_err, 1);
    idle(1, 32'h5555_5555);

    clear_obs();
    rd_en = 1; wr_en = 0; mem_acc_mode = 3'b010; addr = 32'h20; bus_rdata = 32'hCAFE_0000;
    e_addr = 32'h20; e_we = 0; e_strb = 4'b1111; e_wdata = 0;
    set_exp(1, 0, 0, 0, 0); tick();
    bus_req_ready = 1; set_exp(1, 0, 0, 1, 0); tick();
    bus_req_ready = 0; set_exp(1, 0, 0, 0, 0); tick();
    rst = 1; rd_en = 0; set_exp(0, 0, 0, 0, 0); tick();
    rst = 0;
    clear_obs();
    idle(1, 32'hCAFE_0000);
    idle(0, 0);
    check("rst_no_reissue", nvalid, 0);
    access(1, 0, 3'b101, 32'h010, 0, 0, 0, 32'h1234_8001);
    check("lhu_after_rst", obs_rdata, 32'h0000_8001);
    idle(0, 0);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
